// File: rtl/clklanqhdv4.sv
// Integrated clock gate: low-phase transparent enable latch, AND gate, saturating gated-pulse counter.
// Zero-cycle latency (Q pulses on the same edge E/TE is set up for); no backpressure, pure clock path.
module clklanqhdv4 #(
    parameter int CNT_W = 16
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             E,
    input  logic             TE,
    output logic             Q,
    output logic             EN_Q,
    output logic [CNT_W-1:0] ACT_CNT
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic req;
    logic en_lat;

    // TE bypasses reset so scan shift clocking keeps running while RST is held.
    assign req = TE | (E & ~RST);

    // Opaque while CK is high, so the enable cannot change mid-pulse.
    always_latch begin
        if (!CK) begin
            en_lat <= req;
        end
    end

    assign EN_Q = en_lat;
    assign Q    = CK & en_lat;

    // en_lat at the rising edge is the value that opened (or kept closed) this pulse.
    always_ff @(posedge CK) begin
        if (RST) begin
            ACT_CNT <= '0;
        end else if (en_lat && (ACT_CNT != CNT_MAX)) begin
            ACT_CNT <= ACT_CNT + 1'b1;
        end
    end

endmodule

// File: tb/tb_clklanqhdv4.sv
// Bench for clklanqhdv4: directed test-plan scenarios then random E/TE/RST against a cycle model.
module tb_clklanqhdv4;

    logic        CK;
    logic        RST;
    logic        E;
    logic        TE;
    logic        q16;
    logic        en16;
    logic [15:0] cnt16;
    logic        q4;
    logic        en4;
    logic [3:0]  cnt4;

    int checks = 0;
    int errors = 0;
    int m16 = 0;
    int m4  = 0;
    int pulses = 0;

    clklanqhdv4 #(.CNT_W(16)) dut (
        .CK(CK), .RST(RST), .E(E), .TE(TE),
        .Q(q16), .EN_Q(en16), .ACT_CNT(cnt16)
    );

    clklanqhdv4 #(.CNT_W(4)) dut4 (
        .CK(CK), .RST(RST), .E(E), .TE(TE),
        .Q(q4), .EN_Q(en4), .ACT_CNT(cnt4)
    );

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    always @(posedge q16) pulses++;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One full CK cycle: drive in the low phase, sample in the following high phase.
    task automatic step(input logic e, input logic te, input logic rst);
        logic r;
        @(negedge CK);
        #1;
        E = e; TE = te; RST = rst;
        r = te | (e & ~rst);
        #1;
        checkb("en_low_phase", en16, r);
        checkb("q_low_phase", q16, 1'b0);
        @(posedge CK);
        #1;
        if (rst) begin
            m16 = 0;
            m4  = 0;
        end else if (r) begin
            if (m16 < 65535) m16++;
            if (m4 < 15) m4++;
        end
        checkb("q_high", q16, r);
        checkb("en_high", en16, r);
        checkb("q4_high", q4, r);
        check("cnt16", int'(cnt16), m16);
        check("cnt4", int'(cnt4), m4);
    endtask

    initial begin
        int p0;
        E = 1'b0; TE = 1'b0; RST = 1'b1;

        // Reset with E high, then enable for 5 edges.
        step(1, 0, 1);
        step(1, 0, 1);
        check("reset_cnt", int'(cnt16), 0);
        checkb("reset_en", en16, 1'b0);
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        check("after5_cnt", int'(cnt16), 5);

        // Gating on/off: 3 on, 4 off, 2 on.
        step(0, 0, 1);
        p0 = pulses;
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0);
        for (int i = 0; i < 2; i++) step(1, 0, 0);
        check("gating_pulses", pulses - p0, 5);
        check("gating_cnt", int'(cnt16), 5);

        // Glitch immunity: E toggles during the high phase of a closed cycle.
        step(0, 0, 0);
        p0 = pulses;
        E = 1'b1;
        #1;
        checkb("glitch_q_on", q16, 1'b0);
        checkb("glitch_en_on", en16, 1'b0);
        E = 1'b0;
        #1;
        checkb("glitch_q_off", q16, 1'b0);
        check("glitch_cnt", int'(cnt16), 5);
        check("glitch_pulses", pulses - p0, 0);

        // Test-enable override under reset, then without reset.
        p0 = pulses;
        for (int i = 0; i < 3; i++) step(0, 1, 1);
        check("te_rst_pulses", pulses - p0, 3);
        check("te_rst_cnt", int'(cnt16), 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        check("te_cnt", int'(cnt16), 3);

        // Saturation on the 4-bit instance.
        step(1, 0, 1);
        p0 = pulses;
        for (int i = 0; i < 20; i++) step(1, 0, 0);
        check("sat_cnt4", int'(cnt4), 15);
        check("sat_pulses", pulses - p0, 20);
        check("sat_cnt16", int'(cnt16), 20);

        // Mid-run reset: edges 1..5 count, edge 6 reset, edge 7 restarts at 1.
        step(1, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        p0 = pulses;
        step(1, 0, 1);
        check("midrst_pulses", pulses - p0, 0);
        check("midrst_cnt", int'(cnt16), 0);
        step(1, 0, 0);
        check("midrst_restart", int'(cnt16), 1);

        // E and TE together behave as either alone.
        step(1, 1, 0);
        check("both_cnt", int'(cnt16), 2);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 7) == 0),
                 logic'($urandom_range(0, 15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
